mem_rd_parity_checker: RTL
==========================

// Module: mem_rd_parity_checker
// PURPOSE
//  Downstream read stage for the parity-protected word memory (9-bit words: bit 8 = even-parity bit).
//  - Accepts read requests on a valid/ready port and drives the memory read strobe and address.
//  - Captures the returned 9-bit word and checks parity.
//  - Returns 8-bit data, address and error flag through a small response FIFO.
//  - Keeps a saturating parity-error count for the testbench scoreboard and status.
// PARAMETERS
//  ADDR_W     32  width of request/memory address
//  RD_LAT     1   cycles from memory sampling mem_read to mem_rdata valid (>=1)
//  RSP_DEPTH  4   response FIFO entries (power of 2, >=2)
//  CNT_W      16  width of parity error counter
// PORTS
//  clk         in   1          single clock; all logic on posedge
//  reset       in   1          synchronous, active-high reset
//  req_valid   in   1          read request present
//  req_ready   out  1          block can accept request this cycle
//  req_addr    in   ADDR_W     request address, sampled on accept
//  mem_read    out  1          memory read strobe, one cycle per request
//  mem_write   out  1          tied 0 (this stage never writes)
//  mem_address out  ADDR_W     address presented with mem_read
//  mem_rdata   in   9          memory word {parity, data[7:0]}
//  rsp_valid   out  1          response FIFO non-empty
//  rsp_ready   in   1          consumer takes head response
//  rsp_data    out  8          head response data = word[7:0]
//  rsp_addr    out  ADDR_W     head response address
//  rsp_perr    out  1          head response parity error (^word != 0)
//  err_count   out  CNT_W      total parity errors seen, saturating
// BEHAVIOUR
//  - Reset (sync, high): FSM->IDLE, FIFO emptied, err_count=0.
//    Outputs next cycle: req_ready=0 for the reset cycle, then 1; mem_read=0, mem_address=0, rsp_valid=0, rsp_*=0.
//    Reset mid-operation drops any in-flight read; a late mem_rdata is ignored.
//  - FSM states:
//    - IDLE: req_ready = (fifo_count < RSP_DEPTH). On req_valid&&req_ready latch addr -> RD.
//    - RD: mem_read=1, mem_address=latched addr for exactly one cycle; load lat_cnt=RD_LAT -> WAIT.
//    - WAIT: decrement lat_cnt each cycle. When lat_cnt==1, at that edge:
//      - sample mem_rdata;
//      - push {addr, word[7:0], ^word} into FIFO;
//      - if ^word==1, increment err_count -> IDLE.
//  - One request outstanding max; req_ready=0 in RD and WAIT.
//    Throughput: one request per 2+RD_LAT cycles.
//  - Latency: accept edge E0 -> mem_read high E0..E1 -> capture at E(1+RD_LAT)
//    -> rsp_valid high next cycle if FIFO was empty (RD_LAT=1: rsp_valid after E2).
//  - mem_address holds last value outside RD; mem_read never high two consecutive cycles.
//  - Parity: even parity over all 9 bits; perr = ^mem_rdata[8:0]. Data never corrected.
//  - FIFO: rsp_* show head entry; pop on rsp_valid&&rsp_ready.
//    - Push and pop in same cycle: count unchanged, order preserved.
//    - Pointers wrap modulo RSP_DEPTH.
//    - Overflow impossible: accept requires free slot and no pop can reduce space.
//    - Pop on empty is ignored.
//  - err_count saturates at all ones; no wrap.
//  - req_addr/req_valid ignored while req_ready=0; requester holds until accepted.
// TESTING
//  1. Reset, then req addr 0x10 with mem word 0x0A5 -> mem_read one cycle with addr 0x10;
//     rsp_valid after E2, rsp_data 0xA5, rsp_perr 0, err_count 0.
//  2. Word 0x107 (0x07, parity 1) -> rsp_perr 0.
//     Corrupted word 0x1A5 -> rsp_perr 1, err_count 1.
//  3. rsp_ready=0, back-to-back requests to 0..5 -> exactly 4 accepted, req_ready stays 0.
//     Then rsp_ready=1 -> responses 0,1,2,3 in order, then 4,5 accepted.
//  4. FIFO holding 1 entry, pop and push on same edge -> count stays 1, correct order, no loss.
//  5. Reset asserted in WAIT -> no push, rsp_valid 0, err_count 0; next request completes normally.
//  6. CNT_W=2, 5 corrupted reads -> err_count sticks at 3.
//     RD_LAT=3 -> capture 4 edges after accept.

Source files
------------

// File: rtl/mem_rd_parity_checker.sv
// rtl/mem_rd_parity_checker.sv - read stage for parity-protected 9-bit word memory
// Issues one read at a time, checks even parity, queues responses in a small FIFO.
module mem_rd_parity_checker #(
    parameter int ADDR_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int RSP_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [8:0]        mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_perr,
    output logic [CNT_W-1:0]  err_count
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int LAT_W = $clog2(RD_LAT + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(RSP_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [LAT_W-1:0] LAT_INIT  = LAT_W'(RD_LAT);
    localparam logic [LAT_W-1:0] LAT_ONE   = LAT_W'(1);
    localparam logic [CNT_W-1:0] ERR_ONE   = CNT_W'(1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [LAT_W-1:0]  lat_cnt;

    logic [7:0]        data_mem [RSP_DEPTH];
    logic [ADDR_W-1:0] addr_mem [RSP_DEPTH];
    logic              perr_mem [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;

    logic push;
    logic pop;
    logic word_perr;

    // Reset gates req_ready combinationally so nothing is accepted in the reset cycle.
    assign req_ready   = !reset && (state == ST_IDLE) && (count < DEPTH_CNT);
    assign mem_read    = (state == ST_RD);
    assign mem_write   = 1'b0;
    assign mem_address = addr_q;

    assign word_perr = ^mem_rdata;
    assign push      = (state == ST_WAIT) && (lat_cnt == LAT_ONE);
    assign pop       = rsp_valid && rsp_ready;

    assign rsp_valid = (count != '0);
    assign rsp_data  = rsp_valid ? data_mem[rd_ptr] : '0;
    assign rsp_addr  = rsp_valid ? addr_mem[rd_ptr] : '0;
    assign rsp_perr  = rsp_valid ? perr_mem[rd_ptr] : 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            lat_cnt   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            err_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q <= req_addr;
                        state  <= ST_RD;
                    end
                end
                ST_RD: begin
                    lat_cnt <= LAT_INIT;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    lat_cnt <= lat_cnt - LAT_ONE;
                    if (lat_cnt == LAT_ONE) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (push) begin
                data_mem[wr_ptr] <= mem_rdata[7:0];
                addr_mem[wr_ptr] <= addr_q;
                perr_mem[wr_ptr] <= word_perr;
                wr_ptr           <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (!push && pop) begin
                count <= count - CNT_ONE;
            end

            if (push && word_perr && (err_count != '1)) begin
                err_count <= err_count + ERR_ONE;
            end
        end
    end

endmodule
